// File: rtl/scalar_lsu_pkg.sv
// Shared types and lane-formatting helpers for the scalar load/store unit.
package scalar_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned RSP_W = 38;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
    logic [4:0]  rd;
  } rsp_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] off;
  } meta_t;

  // Illegal funct3 for the direction, or an access not aligned to its size.
  function automatic logic cmd_bad(input logic we, input logic [2:0] funct3,
                                   input logic [1:0] off);
    logic legal;
    logic misal;
    case (funct3)
      F3_B:    begin legal = 1'b1; misal = 1'b0;        end
      F3_H:    begin legal = 1'b1; misal = off[0];      end
      F3_W:    begin legal = 1'b1; misal = (off != 2'b00); end
      F3_BU:   begin legal = !we;  misal = 1'b0;        end
      F3_HU:   begin legal = !we;  misal = off[0];      end
      default: begin legal = 1'b0; misal = 1'b0;        end
    endcase
    return !legal || misal;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_B, F3_BU: return 4'b0001 << off;
      F3_H, F3_HU: return off[1] ? 4'b1100 : 4'b0011;
      default:     return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_replicate(input logic [2:0] funct3,
                                                  input logic [31:0] wdata);
    case (funct3)
      F3_B:    return {4{wdata[7:0]}};
      F3_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] funct3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [31:0] lane;
    case (funct3)
      F3_B, F3_BU: lane = word >> {off, 3'b000};
      F3_H, F3_HU: lane = word >> {off[1], 4'b0000};
      default:     lane = word;
    endcase
    case (funct3)
      F3_B:    return {{24{lane[7]}}, lane[7:0]};
      F3_BU:   return {24'h0, lane[7:0]};
      F3_H:    return {{16{lane[15]}}, lane[15:0]};
      F3_HU:   return {16'h0, lane[15:0]};
      default: return lane;
    endcase
  endfunction

endpackage

// File: rtl/scalar_lsu_if.sv
// Command, response, memory-request and memory-response buses of the scalar LSU.
interface scalar_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;

  logic        t_valid;
  logic        t_ready;
  logic        t_we;
  logic [3:0]  t_mask;
  logic [31:0] t_addr;
  logic [31:0] t_data;

  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  rsp_ready, t_ready, i_valid, i_data,
    output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err,
    output t_valid, t_we, t_mask, t_addr, t_data, i_ready
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output rsp_ready, t_ready, i_valid, i_data,
    input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err,
    input  t_valid, t_we, t_mask, t_addr, t_data, i_ready
  );
endinterface

// File: rtl/lsu_rsp_fifo.sv
// Show-ahead response FIFO; head is valid whenever count is non-zero.
module lsu_rsp_fifo #(
  parameter int unsigned WIDTH = 38,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok;

  assign empty  = (count_q == '0);
  assign pop_ok = pop && !empty;
  assign head   = mem_q[rd_ptr_q];
  assign count  = count_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/scalar_lsu.sv
// Scalar load/store initiator: formats lanes, traps bad accesses, tracks one in-flight load.
module scalar_lsu
  import scalar_lsu_pkg::*;
#(
  parameter int unsigned RSP_DEPTH = 2,
  parameter int unsigned FIXED_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  scalar_lsu_if.slave bus,
  output logic        proto_err
);
  localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;

  if (FIXED_LAT != 1) begin : g_lat_check
    $error("scalar_lsu: only FIXED_LAT == 1 is supported");
  end
  if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_depth_check
    $error("scalar_lsu: RSP_DEPTH must be a power of two >= 2");
  end

  meta_t         meta_q, meta_d;
  logic          meta_valid_q, meta_valid_d;
  logic          proto_err_q, proto_err_d;
  logic          first_cycle_q;
  logic          bad, load_credit, accept;
  logic [CW:0]   occ;
  logic          push, fifo_empty;
  rsp_t          push_entry, head;
  logic [CW-1:0] fifo_count;

  assign bad         = cmd_bad(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
  assign occ         = {1'b0, fifo_count} + (CW + 1)'(meta_valid_q);
  assign load_credit = occ < (CW + 1)'(RSP_DEPTH);
  assign accept      = bus.req_valid && bus.req_ready;

  assign bus.t_we    = bus.req_we;
  assign bus.t_addr  = {bus.req_addr[31:2], 2'b00};
  assign bus.t_mask  = lane_mask(bus.req_funct3, bus.req_addr[1:0]);
  assign bus.t_data  = store_replicate(bus.req_funct3, bus.req_wdata);
  assign bus.i_ready = 1'b1;

  // rst_n gates the handshake so nothing is offered while reset is held.
  always_comb begin
    bus.t_valid   = 1'b0;
    bus.req_ready = 1'b0;
    if (rst_n && bus.req_valid) begin
      if (bad) begin
        bus.req_ready = !meta_valid_q && (fifo_count < CW'(RSP_DEPTH));
      end else begin
        bus.t_valid   = bus.req_we || load_credit;
        bus.req_ready = bus.t_valid && bus.t_ready;
      end
    end
  end

  // Bad commands need meta_valid_q low, so they never collide with a load push.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (meta_valid_q && bus.i_valid) begin
      push            = 1'b1;
      push_entry.data = load_extract(meta_q.funct3, meta_q.off, bus.i_data);
      push_entry.rd   = meta_q.rd;
    end else if (accept && bad) begin
      push           = 1'b1;
      push_entry.err = 1'b1;
      push_entry.rd  = bus.req_we ? 5'd0 : bus.req_rd;
    end
  end

  always_comb begin
    meta_valid_d = accept && !bad && !bus.req_we;
    meta_d       = meta_q;
    if (meta_valid_d) meta_d = '{rd: bus.req_rd, funct3: bus.req_funct3, off: bus.req_addr[1:0]};
    proto_err_d  = proto_err_q
                 || (meta_valid_q && !bus.i_valid)
                 || (!meta_valid_q && bus.i_valid && !first_cycle_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q        <= '0;
      meta_valid_q  <= 1'b0;
      proto_err_q   <= 1'b0;
      first_cycle_q <= 1'b1;
    end else begin
      meta_q        <= meta_d;
      meta_valid_q  <= meta_valid_d;
      proto_err_q   <= proto_err_d;
      first_cycle_q <= 1'b0;
    end
  end

  lsu_rsp_fifo #(
    .WIDTH(RSP_W),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_entry),
    .pop      (bus.rsp_ready),
    .head     (head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_data  = head.data;
  assign bus.rsp_rd    = head.rd;
  assign bus.rsp_err   = head.err;
  assign proto_err     = proto_err_q;
endmodule
